program_counter16: RTL
======================

Name: program_counter16

Overview:
- 16-bit program counter that sits downstream of the 16-bit combinational datapath (inverter/ALU words).
- Captures a jump target from that datapath on `load`, increments on `inc`, and otherwise holds.
- Presents the current address to the instruction-fetch stage over a valid/ready handshake.
- Holds a one-deep pending-load buffer, so a jump issued while fetch is stalled is never lost.

Parameters:
- RESET_ADDR, 16'h0000, address loaded into `out` on reset.
- WIDTH, 16, address width; only 16 is supported and verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in  input  16  jump target from the datapath.
- load  input  1  request to load `in` as the next address.
- inc  input  1  request to advance the address by 1.
- out  output  16  current address to fetch.
- out_valid  output  1  `out` holds an address not yet consumed by fetch.
- out_ready  input  1  fetch accepts `out` this cycle.
- busy  output  1  pending-load buffer is occupied.
- wrap  output  1  single-cycle pulse when an increment rolls 16'hFFFF to 16'h0000.

Behaviour:
- Reset: when reset_n=0 at a rising edge, the following hold on the next cycle regardless of other inputs:
  - out=RESET_ADDR, out_valid=1, busy=0, wrap=0.
  - The pending buffer is cleared.
  - State is RUN.
- accept = out_valid & out_ready. A new address may replace `out` only on a cycle with accept=1.
- State RUN (busy=0), priority load > inc > hold:
  - accept & load: out<=in, out_valid=1.
  - accept & !load & inc: out<=out+1, out_valid=1.
  - accept & !load & !inc: out unchanged, out_valid<=0.
  - !accept & load: pend<=in, go to PENDING.
  - !accept & !load: hold.
  - inc without accept is ignored; no increment is queued.
- State IDLE (out_valid=0, RUN sub-case):
  - load: out<=in, out_valid<=1.
  - inc: out<=out+1, out_valid<=1.
  - Neither: no change.
- State PENDING (busy=1):
  - On accept: out<=pend, out_valid=1, busy<=0, return to RUN.
  - On that same accept cycle, `load`/`inc` are ignored (pend wins).
  - load while !accept: pend<=in; the newest target overwrites.
  - inc is ignored throughout PENDING.
- Arithmetic: increment is modulo 2^16.
  - 16'hFFFF+1 = 16'h0000, and wrap=1 for exactly the following cycle.
  - wrap=0 at all other times.
- Latency: one cycle from an accepted load/inc to the new `out`. No combinational path from `in` to `out`.
- Reset mid-operation: a pending load is discarded; no spurious wrap.
- Simultaneous load & inc: load wins; no wrap pulse.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: PC_WRAP_TRAP_EN.
- When defined:
  - An increment from 16'hFFFF does not wrap. `out` holds 16'hFFFF, out_valid<=0, and a sticky output `trap` (1 bit) goes high.
  - While trap=1, `inc` is ignored.
  - A load (immediate or via PENDING) clears trap and proceeds normally. Reset also clears trap.
  - wrap is never asserted.
- When undefined: the `trap` port is absent and modulo wrap applies as above.

Test Plan:
- Reset then free-run: reset_n=0 for one cycle, then reset_n=1, out_ready=1, inc=1 for 4 cycles -> out sequence 0000, 0001, 0002, 0003, 0004; out_valid=1 throughout; busy=0.
- Jump under stall: out=0010 with out_ready=0; pulse load with in=ABCD, then load with in=1234 -> busy=1 and out stays 0010. Raise out_ready -> next cycle out=1234, busy=0; ABCD never appears.
- Load vs inc priority: out_ready=1, load=1, inc=1, in=00FF -> out=00FF next cycle, wrap=0.
- Wrap: load FFFF, then inc with out_ready=1 -> out=0000 and wrap high for one cycle. With PC_WRAP_TRAP_EN: out stays FFFF, out_valid=0, trap=1; a later load of 0040 -> out=0040 and trap=0.
- Reset mid-pending: busy=1 with pend=5555; assert reset_n=0 -> next cycle out=RESET_ADDR, busy=0. After release with out_ready=1, 5555 is never output.
- Idle resume: out_ready=1 with inc=0 and load=0 -> out_valid drops to 0 with out held. Then inc=1 -> out=out+1 and out_valid=1 on the next cycle.

Source files
------------

// File: rtl/program_counter16.sv
// 16-bit program counter with valid/ready fetch handshake and a one-deep pending-jump buffer.
// Define PC_WRAP_TRAP_EN to trap (sticky `trap`) instead of wrapping on increment past 16'hFFFF.
module program_counter16 #(
    parameter int unsigned     WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = 16'h0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef PC_WRAP_TRAP_EN
    output logic             trap,
`endif
    output logic             wrap
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] pend, pend_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             valid_nxt;
    logic             wrap_nxt;
    logic             accept_c;
    logic             take_load, take_pend, take_inc, take_drop;
    logic             inc_blocked;
`ifdef PC_WRAP_TRAP_EN
    logic             trap_nxt;
    assign inc_blocked = trap;
`else
    assign inc_blocked = 1'b0;
`endif

    assign accept_c = out_valid & out_ready;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pend      <= '0;
            out       <= RESET_ADDR;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            wrap      <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
            trap      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
            busy      <= (state_nxt == ST_PEND);
            wrap      <= wrap_nxt;
`ifdef PC_WRAP_TRAP_EN
            trap      <= trap_nxt;
`endif
        end
    end

    // Next-state: pick one action per cycle, then apply it
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        out_nxt   = out;
        valid_nxt = out_valid;
        wrap_nxt  = 1'b0;
        take_load = 1'b0;
        take_pend = 1'b0;
        take_inc  = 1'b0;
        take_drop = 1'b0;
`ifdef PC_WRAP_TRAP_EN
        trap_nxt  = trap;
`endif

        case (state)
            ST_RUN: begin
                if (accept_c) begin
                    if (load)      take_load = 1'b1;
                    else if (inc)  take_inc  = 1'b1;
                    else           take_drop = 1'b1;
                end else if (load) begin
                    pend_nxt  = in;
                    state_nxt = ST_PEND;
                end
            end
            ST_IDLE: begin
                if (load)                      take_load = 1'b1;
                else if (inc && !inc_blocked)  take_inc  = 1'b1;
            end
            ST_PEND: begin
                if (accept_c)  take_pend = 1'b1;
                else if (load) pend_nxt  = in;
            end
            default: state_nxt = ST_RUN;
        endcase

        if (take_load || take_pend) begin
            out_nxt   = take_load ? in : pend;
            valid_nxt = 1'b1;
            state_nxt = ST_RUN;
`ifdef PC_WRAP_TRAP_EN
            trap_nxt  = 1'b0;
`endif
        end

        if (take_drop) begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
        end

        if (take_inc) begin
`ifdef PC_WRAP_TRAP_EN
            // Saturate at the top address and park in IDLE until a load arrives
            if (out == '1) begin
                valid_nxt = 1'b0;
                trap_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                out_nxt   = out + WIDTH'(1);
                valid_nxt = 1'b1;
                state_nxt = ST_RUN;
            end
`else
            out_nxt   = out + WIDTH'(1);
            wrap_nxt  = (out == '1);
            valid_nxt = 1'b1;
            state_nxt = ST_RUN;
`endif
        end
    end

endmodule
